// File: rtl/beta_decode_stage_if.sv
// Fetch-to-decode and decode-to-control handshake bundle for beta_decode_stage.
// The slave modport is the stage's view; the master modport drives fetch and consumes results.
interface beta_decode_stage_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] imm_o;
    logic [8:0]      cu_addr_o;
    logic            invalid_instr_o;

    modport master (
        output instr_i, pc_i, instr_valid_i, dec_ready_i,
        input  instr_ready_o, dec_valid_o, pc_o, rs1_o, rs2_o, rd_o,
               imm_o, cu_addr_o, invalid_instr_o
    );

    modport slave (
        input  instr_i, pc_i, instr_valid_i, dec_ready_i,
        output instr_ready_o, dec_valid_o, pc_o, rs1_o, rs2_o, rd_o,
               imm_o, cu_addr_o, invalid_instr_o
    );
endinterface

// File: rtl/beta_decode_stage.sv
// Registered RV32I/RV32E decode stage with a 2-entry skid buffer so that
// instr_ready_o never depends combinationally on dec_ready_i.
module beta_decode_stage #(
    parameter int XLEN          = 32,
    parameter bit RV32E         = 1'b0,
    parameter bit STRICT_FUNCT7 = 1'b1
) (
    input logic                clk_i,
    input logic                rstn_i,
    input logic                flush_i,
    beta_decode_stage_if.slave bus
);
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_MISC   = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [8:0]      cu;
        logic            inv;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;
    entry_t dec, out_q, skid_q;
    logic   accept, load_out, load_skid, out_from_skid;

    logic [31:0] instr;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic        known, f7_bad, e_bad, f7b, f3_zero;

    assign instr = bus.instr_i;
    assign opc   = instr[6:2];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    always_comb begin
        imm32   = '0;
        known   = 1'b1;
        f7_bad  = 1'b0;
        e_bad   = 1'b0;
        f7b     = 1'b0;
        f3_zero = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                e_bad = instr[11] | instr[19];
            end
            OPC_OPIMM: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                e_bad = instr[11] | instr[19];
                if (f3 == 3'd1) f7_bad = (f7 != 7'h00);
                if (f3 == 3'd5) begin
                    f7_bad = (f7 != 7'h00) && (f7 != 7'h20);
                    f7b    = f7[5];
                end
            end
            OPC_SYSTEM: imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                e_bad = instr[19] | instr[24];
            end
            OPC_BRANCH: begin
                imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                e_bad = instr[19] | instr[24];
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = {instr[31:12], 12'b0};
                e_bad   = instr[11];
                f3_zero = 1'b1;
            end
            OPC_JAL: begin
                imm32   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                e_bad   = instr[11];
                f3_zero = 1'b1;
            end
            OPC_OP: begin
                // funct7=0x20 is only SUB and SRA
                f7_bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
                e_bad  = instr[11] | instr[19] | instr[24];
                f7b    = f7[5];
            end
            OPC_MISC: ;
            default: known = 1'b0;
        endcase

        dec.pc  = bus.pc_i;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        dec.imm = XLEN'($signed(imm32));
        dec.inv = (instr[1:0] != 2'b11) || !known || (STRICT_FUNCT7 && f7_bad) || (RV32E && e_bad);
        dec.cu  = dec.inv ? 9'h1FF : {opc, (f3_zero ? 3'b000 : f3), f7b};
    end

    assign bus.instr_ready_o = (state != FULL) && rstn_i;
    assign accept            = bus.instr_valid_i && bus.instr_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || flush_i) state <= EMPTY;
        else                    state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                load_out  = 1'b1;
            end
            ONE: begin
                if (accept && bus.dec_ready_i) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (bus.dec_ready_i) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (bus.dec_ready_i) begin
                state_nxt     = ONE;
                load_out      = 1'b1;
                out_from_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Flush only gates the loads; stale data in the registers is harmless.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_q  <= '0;
            skid_q <= '0;
        end else if (!flush_i) begin
            if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign bus.dec_valid_o     = (state != EMPTY);
    assign bus.pc_o            = out_q.pc;
    assign bus.rs1_o           = out_q.rs1;
    assign bus.rs2_o           = out_q.rs2;
    assign bus.rd_o            = out_q.rd;
    assign bus.imm_o           = out_q.imm;
    assign bus.cu_addr_o       = out_q.cu;
    assign bus.invalid_instr_o = out_q.inv;
endmodule
